// File: rtl/line_buffer_3rows_ctrl_if.sv
// Pixel-in / RAM-port / column-out bundle of the 3-row line buffer controller.
// slave = controller side, master = stream source, line RAMs and window stage.
interface line_buffer_3rows_ctrl_if #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 12
);
    logic                    i_sof;
    logic                    i_valid;
    logic [P_DATA_WIDTH-1:0] i_data;
    logic                    o_ready;

    logic [P_ADDR_WIDTH-1:0] o_addra;
    logic                    o_ena1;
    logic                    o_ena2;
    logic                    o_wea1;
    logic                    o_wea2;
    logic [P_DATA_WIDTH-1:0] o_dina;
    logic [P_DATA_WIDTH-1:0] i_douta1;
    logic [P_DATA_WIDTH-1:0] i_douta2;

    logic                    o_valid;
    logic [P_DATA_WIDTH-1:0] o_top;
    logic [P_DATA_WIDTH-1:0] o_mid;
    logic [P_DATA_WIDTH-1:0] o_bot;
    logic [P_ADDR_WIDTH-1:0] o_col;
    logic [15:0]             o_row;
    logic                    o_eof;

    modport slave (
        input  i_sof, i_valid, i_data, i_douta1, i_douta2,
        output o_ready, o_addra, o_ena1, o_ena2, o_wea1, o_wea2, o_dina,
        output o_valid, o_top, o_mid, o_bot, o_col, o_row, o_eof
    );

    modport master (
        output i_sof, i_valid, i_data, i_douta1, i_douta2,
        input  o_ready, o_addra, o_ena1, o_ena2, o_wea1, o_wea2, o_dina,
        input  o_valid, o_top, o_mid, o_bot, o_col, o_row, o_eof
    );
endinterface

// File: rtl/line_buffer_3rows_ctrl.sv
// Sequences two one-row line RAMs with rotating roles and emits aligned
// 3-pixel columns (rows y-2, y-1, y) one cycle after each accepted pixel.
module line_buffer_3rows_ctrl #(
    parameter int P_ROW_WIDTH  = 256,
    parameter int P_IMG_HEIGHT = 256,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 12
) (
    input  logic                         clka,
    input  logic                         rsta_n,
    line_buffer_3rows_ctrl_if.slave      bus
);
    localparam logic [P_ADDR_WIDTH-1:0] LP_LAST_COL = P_ADDR_WIDTH'(P_ROW_WIDTH - 1);
    localparam logic [15:0]             LP_LAST_ROW = 16'(P_IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_ready;
    logic [P_ADDR_WIDTH-1:0] r_col;
    logic [15:0]             r_row;
    logic                    r_sel;

    logic                    w_take;
    logic                    w_wrap;
    logic                    w_last_row;
    logic [P_ADDR_WIDTH-1:0] w_col;
    logic [15:0]             w_row;
    logic                    w_sel;

    logic                    r_acc_d;
    logic                    r_sel_d;
    logic                    r_valid;
    logic                    r_eof;
    logic [P_DATA_WIDTH-1:0] r_bot;
    logic [P_DATA_WIDTH-1:0] r_top;
    logic [P_DATA_WIDTH-1:0] r_mid;
    logic [P_ADDR_WIDTH-1:0] r_col_d;
    logic [15:0]             r_row_d;
    logic [P_DATA_WIDTH-1:0] w_top;
    logic [P_DATA_WIDTH-1:0] w_mid;

    // A sof pixel restarts the frame, so it sees zeroed position and RAM role.
    always_comb begin
        w_take     = bus.i_valid & r_ready & ((r_state != ST_IDLE) | bus.i_sof);
        w_col      = bus.i_sof ? '0 : r_col;
        w_row      = bus.i_sof ? '0 : r_row;
        w_sel      = bus.i_sof ? 1'b0 : r_sel;
        w_wrap     = (w_col == LP_LAST_COL);
        w_last_row = (w_row == LP_LAST_ROW);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_take) begin
            if (w_wrap && w_row == 16'd1)
                w_state_nxt = ST_RUN;
            else if (w_wrap && w_last_row)
                w_state_nxt = ST_IDLE;
            else if (bus.i_sof)
                w_state_nxt = ST_FILL;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        bus.o_addra = '0;
        bus.o_ena1  = 1'b0;
        bus.o_ena2  = 1'b0;
        bus.o_wea1  = 1'b0;
        bus.o_wea2  = 1'b0;
        bus.o_dina  = '0;
        if (w_take) begin
            bus.o_addra = w_col;
            bus.o_ena1  = 1'b1;
            bus.o_ena2  = 1'b1;
            bus.o_wea1  = ~w_sel;
            bus.o_wea2  = w_sel;
            bus.o_dina  = bus.i_data;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_ready <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_sel   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (w_take) begin
                if (w_wrap) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : w_row + 16'd1;
                    r_sel <= ~w_sel;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                    r_sel <= w_sel;
                end
            end
        end
    end

    // RAM read data arrives one cycle after the access; the column is formed
    // straight from it and captured so it holds through gap cycles.
    always_comb begin
        w_top = r_acc_d ? (r_sel_d ? bus.i_douta2 : bus.i_douta1) : r_top;
        w_mid = r_acc_d ? (r_sel_d ? bus.i_douta1 : bus.i_douta2) : r_mid;
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_acc_d <= 1'b0;
            r_sel_d <= 1'b0;
            r_valid <= 1'b0;
            r_eof   <= 1'b0;
            r_bot   <= '0;
            r_top   <= '0;
            r_mid   <= '0;
            r_col_d <= '0;
            r_row_d <= '0;
        end else begin
            r_acc_d <= w_take;
            r_valid <= w_take & (w_row >= 16'd2);
            r_eof   <= w_take & w_wrap & w_last_row;
            r_top   <= w_top;
            r_mid   <= w_mid;
            if (w_take) begin
                r_sel_d <= w_sel;
                r_bot   <= bus.i_data;
                r_col_d <= w_col;
                r_row_d <= w_row;
            end
        end
    end

    always_comb begin
        bus.o_ready = r_ready;
        bus.o_valid = r_valid;
        bus.o_eof   = r_eof;
        bus.o_top   = w_top;
        bus.o_mid   = w_mid;
        bus.o_bot   = r_bot;
        bus.o_col   = r_col_d;
        bus.o_row   = r_row_d;
    end
endmodule

// File: tb/tb_line_buffer_3rows_ctrl.sv
// Directed bench for line_buffer_3rows_ctrl on a 4x4 frame with behavioural
// read-first line RAMs.
module tb_line_buffer_3rows_ctrl;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int AW = 12;

    logic clka;
    logic rsta_n;
    int   n_checks;
    int   n_fail;

    line_buffer_3rows_ctrl_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bus ();

    line_buffer_3rows_ctrl #(
        .P_ROW_WIDTH (W),
        .P_IMG_HEIGHT(H),
        .P_DATA_WIDTH(DW),
        .P_ADDR_WIDTH(AW)
    ) dut (
        .clka  (clka),
        .rsta_n(rsta_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem1 [0:W-1];
    logic [DW-1:0] mem2 [0:W-1];

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Read-first single-port RAMs, output held while disabled.
    always @(posedge clka) begin
        if (bus.o_ena1) begin
            bus.i_douta1 <= mem1[bus.o_addra[1:0]];
            if (bus.o_wea1) mem1[bus.o_addra[1:0]] <= bus.o_dina;
        end
        if (bus.o_ena2) begin
            bus.i_douta2 <= mem2[bus.o_addra[1:0]];
            if (bus.o_wea2) mem2[bus.o_addra[1:0]] <= bus.o_dina;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_cycle();
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_data  = '0;
        @(posedge clka); #1;
    endtask

    // Sends a 4x4 frame pixel = base+16*row+col, starting at posedge+1.
    // Stops before pixel (stop_r,stop_c) when that lies inside the frame.
    task automatic send_frame(input logic [7:0] base, input bit gapped,
                              input int stop_r, input int stop_c);
        logic [7:0] pix;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                pix = base + 8'(16 * r + c);
                bus.i_sof   = (r == 0 && c == 0);
                bus.i_valid = 1'b1;
                bus.i_data  = pix;
                #1;
                check_eq("addra", 32'(bus.o_addra), 32'(c));
                check_eq("ena",   {30'd0, bus.o_ena1, bus.o_ena2}, 32'b11);
                check_eq("wea",   {30'd0, bus.o_wea1, bus.o_wea2}, (r % 2 == 0) ? 32'b10 : 32'b01);
                check_eq("dina",  32'(bus.o_dina), 32'(pix));
                @(posedge clka); #1;
                check_eq("valid", 32'(bus.o_valid), 32'(r >= 2));
                check_eq("eof",   32'(bus.o_eof), 32'(r == H - 1 && c == W - 1));
                check_eq("bot",   32'(bus.o_bot), 32'(pix));
                if (r >= 2) begin
                    check_eq("top", 32'(bus.o_top), 32'(8'(base + 8'(16 * (r - 2) + c))));
                    check_eq("mid", 32'(bus.o_mid), 32'(8'(base + 8'(16 * (r - 1) + c))));
                    check_eq("col", 32'(bus.o_col), 32'(c));
                    check_eq("row", 32'(bus.o_row), 32'(r));
                end
                if (gapped) begin
                    bus.i_sof   = 1'b0;
                    bus.i_valid = 1'b0;
                    bus.i_data  = 8'($urandom_range(0, 255));
                    #1;
                    check_eq("gap_ena",  {30'd0, bus.o_ena1, bus.o_ena2}, 32'd0);
                    check_eq("gap_wea",  {30'd0, bus.o_wea1, bus.o_wea2}, 32'd0);
                    check_eq("gap_dina", 32'(bus.o_dina), 32'd0);
                    @(posedge clka); #1;
                    check_eq("gap_valid", 32'(bus.o_valid), 32'd0);
                    check_eq("gap_eof",   32'(bus.o_eof), 32'd0);
                    check_eq("gap_bot",   32'(bus.o_bot), 32'(pix));
                    if (r >= 2)
                        check_eq("gap_top", 32'(bus.o_top), 32'(8'(base + 8'(16 * (r - 2) + c))));
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        check_eq({tag, "_eof"},   32'(bus.o_eof), 32'd0);
        check_eq({tag, "_ready"}, 32'(bus.o_ready), 32'd0);
        check_eq({tag, "_ena"},   {30'd0, bus.o_ena1, bus.o_ena2}, 32'd0);
        check_eq({tag, "_top"},   32'(bus.o_top), 32'd0);
        check_eq({tag, "_mid"},   32'(bus.o_mid), 32'd0);
        check_eq({tag, "_bot"},   32'(bus.o_bot), 32'd0);
        check_eq({tag, "_col"},   32'(bus.o_col), 32'd0);
        check_eq({tag, "_row"},   32'(bus.o_row), 32'd0);
        check_eq({tag, "_addra"}, 32'(bus.o_addra), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rsta_n      = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_douta1 = '0;
        bus.i_douta2 = '0;
        repeat (3) @(posedge clka);
        #1;
        check_reset_outputs("rst");
        rsta_n = 1'b1;
        @(posedge clka); #1;
        check_eq("ready", 32'(bus.o_ready), 32'd1);

        // Basic continuous frame and RAM role rotation.
        send_frame(8'h00, 1'b0, -1, -1);
        idle_cycle();
        check_eq("post_valid", 32'(bus.o_valid), 32'd0);

        // Gapped input.
        send_frame(8'h00, 1'b1, -1, -1);
        idle_cycle();

        // Mid-frame sof at row 2 col 1 restarts with a fresh frame.
        send_frame(8'h40, 1'b0, 2, 1);
        send_frame(8'h80, 1'b0, -1, -1);
        idle_cycle();

        // Reset mid-frame at row 3 col 2.
        send_frame(8'h20, 1'b0, 3, 2);
        rsta_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clka); #1;
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        rsta_n = 1'b1;
        @(posedge clka); #1;
        for (int k = 0; k < 3; k++) begin
            bus.i_valid = 1'b1;
            bus.i_sof   = 1'b0;
            bus.i_data  = 8'h77;
            #1;
            check_eq("drop_ena", {30'd0, bus.o_ena1, bus.o_ena2}, 32'd0);
            check_eq("drop_wea", {30'd0, bus.o_wea1, bus.o_wea2}, 32'd0);
            @(posedge clka); #1;
            check_eq("drop_valid", 32'(bus.o_valid), 32'd0);
            check_eq("drop_bot",   32'(bus.o_bot), 32'd0);
        end
        send_frame(8'h30, 1'b0, -1, -1);

        // Back-to-back frames.
        send_frame(8'h00, 1'b0, -1, -1);
        send_frame(8'h50, 1'b0, -1, -1);
        idle_cycle();
        check_eq("end_valid", 32'(bus.o_valid), 32'd0);
        check_eq("end_eof",   32'(bus.o_eof), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/line_buffer_3rows_ctrl.md
Name: line_buffer_3rows_ctrl

Overview:
- Sequencing controller for the two one-row single-port line RAMs (initial_3rows_spram) in the infrared 3x3 window path.
- Accepts a raster pixel stream and writes each pixel into the RAM holding the oldest row. Reads both RAMs at the same column.
- Emits a vertically aligned 3-pixel column (rows y-2, y-1, y) to the downstream window/filter stage.
- Rotates RAM roles per row, so no row copy is ever performed.

Parameters:
- P_ROW_WIDTH, 256, pixels per row; also the RAM depth.
- P_IMG_HEIGHT, 256, rows per frame.
- P_DATA_WIDTH, 8, pixel width.
- P_ADDR_WIDTH, 12, RAM address width; must satisfy 2^P_ADDR_WIDTH >= P_ROW_WIDTH.

Ports:
- clka  in  1  clock for the block and both RAMs.
- rsta_n  in  1  reset, asynchronous assert, active-low.
- i_sof  in  1  start of frame; qualified by i_valid, marks pixel (0,0).
- i_valid  in  1  input pixel valid; one pixel per valid cycle, gaps allowed.
- i_data  in  P_DATA_WIDTH  input pixel.
- o_ready  out  1  high in IDLE/FILL/RUN.
- o_addra  out  P_ADDR_WIDTH  column address, shared by both RAM ports.
- o_ena1, o_ena2  out  1  RAM enables.
- o_wea1, o_wea2  out  1  RAM write enables.
- o_dina  out  P_DATA_WIDTH  write data to both RAMs.
- i_douta1, i_douta2  in  P_DATA_WIDTH  RAM read data. RAMs are read-first, read latency 1.
- o_valid  out  1  output column valid.
- o_top, o_mid, o_bot  out  P_DATA_WIDTH  pixels of rows y-2, y-1, y.
- o_col  out  P_ADDR_WIDTH  column index of the output.
- o_row  out  16  row index y of o_bot.
- o_eof  out  1  high with the last output column of the frame.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, col = row = 0, sel = 0.
- FSM states:
  - IDLE: ignore input until i_valid & i_sof. That pixel is processed as (0,0) and the FSM enters FILL.
  - FILL: rows 0 and 1; RAMs are written, o_valid stays 0. At the end of row 1, go to RUN.
  - RUN: rows 2..P_IMG_HEIGHT-1; a column is output per accepted pixel. After the last pixel of the last row, go to IDLE.
- Per accepted pixel (i_valid & o_ready) at column col:
  - o_addra = col; o_ena1 = o_ena2 = 1; o_dina = i_data.
  - Only RAM[sel] is written (o_wea of that RAM = 1, other = 0).
  - RAM[sel] holds row y-2 (read-first); RAM[~sel] holds row y-1.
  - Enables and write enables are 0 on cycles with no accepted pixel.
- Counters:
  - col increments per accepted pixel. At P_ROW_WIDTH-1 it wraps to 0, row increments, and sel toggles.
  - At the last row's wrap, row returns to 0.
- Output pipeline (latency exactly 1 cycle after acceptance):
  - Registers: o_bot = i_data delayed 1; o_top = douta of RAM[sel_d]; o_mid = douta of RAM[~sel_d]; o_col and o_row delayed 1.
  - o_valid = accepted_d & (row_d >= 2).
  - o_eof = o_valid & last column & last row.
  - o_valid, o_eof, data and indices hold their previous values when no pixel is accepted; o_valid/o_eof drop to 0.
- i_sof while not in IDLE: resynchronise.
  - The pixel is treated as (0,0); col = row = 0, sel = 0, FSM = FILL.
  - Any in-flight output from the previous cycle still completes.
  - Stale RAM content is never emitted, because FILL suppresses output.
- i_sof on any pixel other than the first of a frame in IDLE is handled as above.
- Pixels arriving in IDLE without i_sof are dropped: no RAM access.
- Reset asserted mid-frame: immediate return to the reset state; the next frame needs i_sof.
- Frame smaller than 3 rows is not supported (P_IMG_HEIGHT >= 3, P_ROW_WIDTH >= 2).

Test Plan:
- Basic 4x4 frame: P_ROW_WIDTH=4, P_IMG_HEIGHT=4, pixel = 16*row+col, continuous valid.
  - Response: 8 outputs, none during rows 0-1.
  - First output (row 2, col 0): top=0x00, mid=0x10, bot=0x20.
  - Last output: top=0x13, mid=0x23, bot=0x33, o_eof=1.
- RAM sequencing: same frame.
  - Row 0 writes RAM1, row 1 RAM2, row 2 RAM1, row 3 RAM2.
  - o_addra cycles 0..3; exactly one wea high per accepted pixel.
- Gapped input: i_valid toggling 1/0 across the frame.
  - Identical output sequence; each output exactly 1 cycle after its pixel; ena/wea low in gap cycles.
- Mid-frame sof: assert i_sof at row 2, col 1, then send a fresh 4x4 frame of pixel = 0x80+16*row+col.
  - No output before the new row 2.
  - First new output: top=0x80, mid=0x90, bot=0xA0.
- Reset mid-frame: drop rsta_n at row 3, col 2.
  - All outputs 0 immediately; pixels without sof are ignored (no ena).
  - The next sof frame produces correct results.
- Back-to-back frames: sof on the cycle after the last pixel.
  - o_eof for frame 1; frame 2 output begins at its row 2 with correct values.
